// File: rtl/ens_vote_argmax.sv
// Ensemble vote accumulator with sequential argmax scan and a valid/ready result port.
// Optional ENS_VOTE_SATURATE_EN makes accumulators clamp at full scale instead of wrapping.

module ens_vote_lane #(
   parameter int SCORE_W = 2,
   parameter int ACC_W   = 4
) (
   input  logic [ACC_W-1:0]   acc_i,
   input  logic [SCORE_W-1:0] score_i,
   output logic [ACC_W-1:0]   sum_o
);
   logic [ACC_W:0] wide;

   assign wide = {1'b0, acc_i} + (ACC_W+1)'(score_i);

`ifdef ENS_VOTE_SATURATE_EN
   assign sum_o = wide[ACC_W] ? {ACC_W{1'b1}} : wide[ACC_W-1:0];
`else
   assign sum_o = wide[ACC_W-1:0];
`endif
endmodule

module ens_vote_argmax #(
   parameter int NUM_CLASSES = 10,
   parameter int SCORE_W     = 2,
   parameter int ACC_W       = 4,
   parameter int IDX_W       = 4
) (
   input  logic                           clk_i,
   input  logic                           rst_i,
   input  logic                           s_valid_i,
   output logic                           s_ready_o,
   input  logic [NUM_CLASSES*SCORE_W-1:0] s_data_i,
   input  logic                           s_last_i,
   output logic                           m_valid_o,
   input  logic                           m_ready_i,
   output logic [IDX_W-1:0]               m_class_o,
   output logic [ACC_W-1:0]               m_score_o,
   output logic [7:0]                     m_members_o
);
   typedef enum logic [1:0] {S_ACCUM, S_SCAN, S_OUT} state_e;

   state_e                              state_q;
   logic [NUM_CLASSES-1:0][ACC_W-1:0]   acc_q, acc_d;
   logic [7:0]                          members_q, members_d;
   logic [IDX_W-1:0]                    scan_idx_q;
   logic [IDX_W-1:0]                    best_idx_q, best_idx_d;
   logic [ACC_W-1:0]                    best_score_q, best_score_d;
   logic                                s_ready_q, m_valid_q;
   logic [IDX_W-1:0]                    m_class_q;
   logic [ACC_W-1:0]                    m_score_q;
   logic [ACC_W-1:0]                    cur_score;
   logic                                take, last_scan, xfer;

   for (genvar k = 0; k < NUM_CLASSES; k++) begin : g_lane
      ens_vote_lane #(.SCORE_W(SCORE_W), .ACC_W(ACC_W)) u_lane (
         .acc_i   (acc_q[k]),
         .score_i (s_data_i[k*SCORE_W +: SCORE_W]),
         .sum_o   (acc_d[k])
      );
   end

   assign xfer      = s_valid_i && s_ready_q;
   assign members_d = (members_q == 8'hFF) ? members_q : members_q + 8'd1;

   // Index 0 seeds the running best; later classes win only on a strict increase.
   assign cur_score    = acc_q[scan_idx_q];
   assign take         = (scan_idx_q == '0) || (cur_score > best_score_q);
   assign best_idx_d   = take ? scan_idx_q : best_idx_q;
   assign best_score_d = take ? cur_score  : best_score_q;
   assign last_scan    = (scan_idx_q == IDX_W'(NUM_CLASSES-1));

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q      <= S_ACCUM;
         acc_q        <= '0;
         members_q    <= '0;
         scan_idx_q   <= '0;
         best_idx_q   <= '0;
         best_score_q <= '0;
         s_ready_q    <= 1'b1;
         m_valid_q    <= 1'b0;
         m_class_q    <= '0;
         m_score_q    <= '0;
      end else begin
         case (state_q)
            S_ACCUM: begin
               if (xfer) begin
                  acc_q     <= acc_d;
                  members_q <= members_d;
                  if (s_last_i) begin
                     state_q    <= S_SCAN;
                     s_ready_q  <= 1'b0;
                     scan_idx_q <= '0;
                  end
               end
            end
            S_SCAN: begin
               best_idx_q   <= best_idx_d;
               best_score_q <= best_score_d;
               if (last_scan) begin
                  state_q   <= S_OUT;
                  m_valid_q <= 1'b1;
                  m_class_q <= best_idx_d;
                  m_score_q <= best_score_d;
               end else begin
                  scan_idx_q <= scan_idx_q + IDX_W'(1);
               end
            end
            S_OUT: begin
               if (m_ready_i) begin
                  state_q   <= S_ACCUM;
                  acc_q     <= '0;
                  members_q <= '0;
                  m_valid_q <= 1'b0;
                  s_ready_q <= 1'b1;
               end
            end
            default: begin
               state_q   <= S_ACCUM;
               s_ready_q <= 1'b1;
               m_valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign s_ready_o   = s_ready_q;
   assign m_valid_o   = m_valid_q;
   assign m_class_o   = m_class_q;
   assign m_score_o   = m_score_q;
   assign m_members_o = members_q;
endmodule
